// File: rtl/vga_pkg.sv
// Shared constants for the VGA frame path: default 640x480@60 timing,
// framebuffer geometry and small helpers used by the counters.
package vga_pkg;

   // Default horizontal timing (pixels), region order: visible, FP, sync, BP
   localparam int H_VISIBLE    = 640;
   localparam int H_FP         = 16;
   localparam int H_SYNC       = 96;
   localparam int H_BP         = 48;
   localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int H_SYNC_START = H_VISIBLE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

   // Default vertical timing (lines)
   localparam int V_VISIBLE    = 480;
   localparam int V_FP         = 10;
   localparam int V_SYNC       = 2;
   localparam int V_BP         = 33;
   localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int V_SYNC_START = V_VISIBLE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   // Pixel replication and VRAM read latency defaults
   localparam int SCALE  = 5;
   localparam int RD_LAT = 1;

   // Address is {row, col}; each coordinate indexes up to 128 entries
   localparam int ADDR_W  = 14;
   localparam int COORD_W = 7;
   localparam int CNT_W   = 10;

   // Inactive value of one delay-line stage: {video_on, hsync_n, vsync_n}
   localparam logic [2:0] DLY_IDLE = 3'b011;

   // True when lo <= value <= hi (inclusive window test on counter values)
   function automatic logic in_window(input logic [CNT_W-1:0] value,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (value >= lo) && (value <= hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrap counter for one VGA axis. Advances on step, wraps after the
// last position of visible+FP+sync+BP. The visible/sync flags describe either
// the current count or, with LOOKAHEAD set, the count being loaded this cycle
// (used when the output stage must be registered with zero extra latency).
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int VISIBLE   = 640,
   parameter int FP        = 16,
   parameter int SYNC      = 96,
   parameter int BP        = 48,
   parameter bit LOOKAHEAD = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   output logic [CNT_W-1:0] count,
   output logic             visible,
   output logic             sync,
   output logic             wrap
);

   localparam int TOTAL = VISIBLE + FP + SYNC + BP;
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] ZERO    = CNT_W'(0);
   localparam logic [CNT_W-1:0] VIS_END = CNT_W'(VISIBLE - 1);
   localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VISIBLE + FP);
   localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VISIBLE + FP + SYNC - 1);

   if (TOTAL > (1 << CNT_W)) begin : g_total_too_big
      $error("vga_axis_counter: axis total does not fit the counter width");
   end

   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] probe_s;

   // Next count, wrap pulse and region flags
   always_comb begin
      count_d = count_q;
      wrap    = 1'b0;
      if (step) begin
         if (count_q == LAST) begin
            count_d = ZERO;
            wrap    = 1'b1;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end else begin
         count_d = count_q;
      end
      probe_s = LOOKAHEAD ? count_d : count_q;
      visible = in_window(probe_s, ZERO, VIS_END);
      sync    = in_window(probe_s, SYNC_LO, SYNC_HI);
   end

   // Counter register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= ZERO;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/vga_frame_controller.sv
// VGA frame sequencer: H/V timing, 128x96 framebuffer addressing with SCALE x
// SCALE pixel replication, and a sync/video-enable delay line matching the
// VRAM read latency. Every state element advances only on pix_en.
module vga_frame_controller
   import vga_pkg::ADDR_W, vga_pkg::COORD_W, vga_pkg::CNT_W, vga_pkg::DLY_IDLE;
#(
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FP      = vga_pkg::H_FP,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BP      = vga_pkg::H_BP,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FP      = vga_pkg::V_FP,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BP      = vga_pkg::V_BP,
   parameter int SCALE     = vga_pkg::SCALE,
   parameter int RD_LAT    = vga_pkg::RD_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_en,
   output logic [ADDR_W-1:0] address,
   output logic              video_on,
   output logic              VGA_HSYNC,
   output logic              VGA_VSYNC,
   output logic              frame_start
);

   localparam int COLS  = H_VISIBLE / SCALE;
   localparam int ROWS  = V_VISIBLE / SCALE;
   localparam int REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(SCALE - 1);
   localparam logic [CNT_W-1:0] H_LAST_VIS = CNT_W'(H_VISIBLE - 1);
   localparam logic [CNT_W-1:0] V_LAST_VIS = CNT_W'(V_VISIBLE - 1);
   localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
   // RD_LAT=0 still needs one register, fed from the position being loaded
   localparam int NSTG      = (RD_LAT == 0) ? 1 : RD_LAT;
   localparam bit LOOKAHEAD = (RD_LAT == 0);

   if (COLS > 128) begin : g_cols_too_many
      $error("vga_frame_controller: H_VISIBLE/SCALE exceeds 128 columns");
   end
   if (ROWS > 128) begin : g_rows_too_many
      $error("vga_frame_controller: V_VISIBLE/SCALE exceeds 128 rows");
   end
   if ((RD_LAT < 0) || (RD_LAT > 3)) begin : g_bad_lat
      $error("vga_frame_controller: RD_LAT must be 0..3");
   end

   logic [CNT_W-1:0]   hcount_s;
   logic [CNT_W-1:0]   vcount_s;
   logic               h_vis_s;
   logic               h_sync_s;
   logic               h_wrap_s;
   logic               v_vis_s;
   logic               v_sync_s;
   logic               v_wrap_s;
   logic [2:0]         cur_s;

   logic [REP_W-1:0]   hrep_d, hrep_q;
   logic [REP_W-1:0]   vrep_d, vrep_q;
   logic [COORD_W-1:0] col_d, col_q;
   logic [COORD_W-1:0] row_d, row_q;
   logic               first_d, first_q;
   logic [2:0]         dly_d [NSTG];
   logic [2:0]         dly_q [NSTG];

   vga_axis_counter #(
      .VISIBLE   (H_VISIBLE),
      .FP        (H_FP),
      .SYNC      (H_SYNC),
      .BP        (H_BP),
      .LOOKAHEAD (LOOKAHEAD)
   ) u_hcnt (
      .clk     (clk),
      .reset   (reset),
      .step    (pix_en),
      .count   (hcount_s),
      .visible (h_vis_s),
      .sync    (h_sync_s),
      .wrap    (h_wrap_s)
   );

   vga_axis_counter #(
      .VISIBLE   (V_VISIBLE),
      .FP        (V_FP),
      .SYNC      (V_SYNC),
      .BP        (V_BP),
      .LOOKAHEAD (LOOKAHEAD)
   ) u_vcnt (
      .clk     (clk),
      .reset   (reset),
      .step    (h_wrap_s),
      .count   (vcount_s),
      .visible (v_vis_s),
      .sync    (v_sync_s),
      .wrap    (v_wrap_s)
   );

   // Replication counters, frame-start arming and delay-line shifting
   always_comb begin
      hrep_d  = hrep_q;
      vrep_d  = vrep_q;
      col_d   = col_q;
      row_d   = row_q;
      first_d = first_q;
      for (int i = 0; i < NSTG; i++) begin
         dly_d[i] = dly_q[i];
      end
      cur_s = {h_vis_s & v_vis_s, ~h_sync_s, ~v_sync_s};

      if (pix_en) begin
         // Column advances inside visible lines; cleared when leaving the
         // visible span of the line and throughout vertical blanking
         if ((hcount_s < H_LAST_VIS) && (vcount_s < V_VIS)) begin
            if (hrep_q == REP_LAST) begin
               hrep_d = {REP_W{1'b0}};
               col_d  = col_q + COORD_W'(1);
            end else begin
               hrep_d = hrep_q + REP_W'(1);
            end
         end else begin
            hrep_d = {REP_W{1'b0}};
            col_d  = {COORD_W{1'b0}};
         end

         // Row advances once per SCALE visible lines, cleared after the last
         if (h_wrap_s) begin
            if (vcount_s < V_LAST_VIS) begin
               if (vrep_q == REP_LAST) begin
                  vrep_d = {REP_W{1'b0}};
                  row_d  = row_q + COORD_W'(1);
               end else begin
                  vrep_d = vrep_q + REP_W'(1);
               end
            end else begin
               vrep_d = {REP_W{1'b0}};
               row_d  = {COORD_W{1'b0}};
            end
         end else begin
            vrep_d = vrep_q;
            row_d  = row_q;
         end

         first_d  = 1'b0;
         dly_d[0] = cur_s;
         for (int i = 1; i < NSTG; i++) begin
            dly_d[i] = dly_q[i-1];
         end
      end else begin
         first_d = first_q;
      end
   end

   // frame_start is qualified by pix_en so it is one clk wide at any pix rate
   always_comb begin
      frame_start = 1'b0;
      if (reset) begin
         frame_start = 1'b0;
      end else begin
         frame_start = (pix_en & first_q) | v_wrap_s;
      end
   end

   // State registers with synchronous reset to pixel (0,0)
   always_ff @(posedge clk) begin
      if (reset) begin
         hrep_q  <= {REP_W{1'b0}};
         vrep_q  <= {REP_W{1'b0}};
         col_q   <= {COORD_W{1'b0}};
         row_q   <= {COORD_W{1'b0}};
         first_q <= 1'b1;
         for (int i = 0; i < NSTG; i++) begin
            dly_q[i] <= DLY_IDLE;
         end
      end else begin
         hrep_q  <= hrep_d;
         vrep_q  <= vrep_d;
         col_q   <= col_d;
         row_q   <= row_d;
         first_q <= first_d;
         for (int i = 0; i < NSTG; i++) begin
            dly_q[i] <= dly_d[i];
         end
      end
   end

   assign address = {row_q, col_q};
   assign {video_on, VGA_HSYNC, VGA_VSYNC} = dly_q[NSTG-1];

endmodule

// File: tb/tb_vga_frame_controller.sv
// Randomized bench for vga_frame_controller on a reduced screen geometry so
// several whole frames fit in a short run. Expected outputs come from a
// position model: the number of pix_en ticks since reset fixes (h,v).
module tb_vga_frame_controller;

   localparam int HV = 40, HF = 4, HS = 6, HB = 6;
   localparam int VV = 20, VF = 2, VS = 2, VB = 3;
   localparam int SC = 5, LAT = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_en = 1'b0;
   logic [13:0] address;
   logic        video_on;
   logic        hsync_n;
   logic        vsync_n;
   logic        frame_start;

   int     n_checks = 0;
   int     n_pass = 0;
   longint p_abs = 0;
   longint prev_fs = -1;

   always #5 clk = ~clk;

   vga_frame_controller #(
      .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .SCALE (SC), .RD_LAT (LAT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pix_en      (pix_en),
      .address     (address),
      .video_on    (video_on),
      .VGA_HSYNC   (hsync_n),
      .VGA_VSYNC   (vsync_n),
      .frame_start (frame_start)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, got, exp, p_abs);
      end
   endtask

   // One clk: drive inputs, compare outputs against the model, then advance it
   task automatic step(input bit r, input bit pe);
      longint h, v, q, hq, vq;
      int e_addr;
      bit e_vis, e_hs, e_vs, e_fs;
      @(negedge clk);
      reset  = r;
      pix_en = pe;
      #1;
      h = p_abs % HT;
      v = (p_abs / HT) % VT;
      e_addr = ((v < VV) ? int'(v / SC) : 0) * 128 + ((h < HV && v < VV) ? int'(h / SC) : 0);
      if (p_abs >= LAT) begin
         q  = p_abs - LAT;
         hq = q % HT;
         vq = (q / HT) % VT;
         e_vis = (hq < HV) && (vq < VV);
         e_hs  = !((hq >= HV + HF) && (hq < HV + HF + HS));
         e_vs  = !((vq >= VV + VF) && (vq < VV + VF + VS));
      end else begin
         e_vis = 1'b0;
         e_hs  = 1'b1;
         e_vs  = 1'b1;
      end
      e_fs = !r && pe && (p_abs == 0 || (h == HT - 1 && v == VT - 1));
      check_eq("address", 32'(address), 32'(e_addr));
      check_eq("video_on", 32'(video_on), 32'(e_vis));
      check_eq("hsync_n", 32'(hsync_n), 32'(e_hs));
      check_eq("vsync_n", 32'(vsync_n), 32'(e_vs));
      check_eq("frame_start", 32'(frame_start), 32'(e_fs));
      if (frame_start === 1'b1 && !r) begin
         if (prev_fs > 0) begin
            check_eq("fs_spacing", 32'(p_abs - prev_fs), 32'(FRAME));
         end
         prev_fs = p_abs;
      end
      @(posedge clk);
      if (r) begin
         p_abs   = 0;
         prev_fs = -1;
      end else if (pe) begin
         p_abs++;
      end
   endtask

   // Random pix_en until the model sits at (h0,v0); bounded by a cycle budget
   task automatic run_to(input int h0, input int v0);
      bit ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if ((p_abs % HT) == h0 && ((p_abs / HT) % VT) == v0) begin
            ok = 1'b1;
            break;
         end
         step(1'b0, 1'($urandom_range(0, 1)));
      end
      check_eq("reach_pos", 32'(ok), 32'd1);
   endtask

   initial begin
      // Reset held with pix_en high
      repeat (3) step(1'b1, 1'b1);
      // Two lines with pix_en every 4th clk
      for (int i = 0; i < HT * 4 * 2; i++) step(1'b0, (i % 4) == 3);
      // Random pix_en over several frames
      for (int i = 0; i < FRAME * 3; i++) step(1'b0, $urandom_range(0, 3) != 0);
      // Freeze mid-line for 50 clks
      run_to(20, 3);
      repeat (50) step(1'b0, 1'b0);
      // One-clk reset mid-frame, pix_en high (reset must win)
      run_to(30, 12);
      step(1'b1, 1'b1);
      for (int i = 0; i < FRAME * 3; i++) step(1'b0, $urandom_range(0, 3) != 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
